// File: rtl/dcache_snoop_ctrl_if.sv
// Bundle of the processor-side (dmem*) and coherence-bus-side (d*, cc*)
// signals of one core's data cache.
//   slave  : the cache controller (dcache_snoop_ctrl)
//   master : whatever surrounds the cache (datapath + memory controller)
// Signals:
//   dmemREN/dmemWEN/datomic/dmemaddr/dmemstore -> cache ; dmemload/dhit <- cache
//   dREN/dWEN/daddr/dstore <- cache ; dload/dwait -> cache
//   cctrans/ccwrite <- cache ; ccwait/ccinv/ccsnoopaddr -> cache
interface dcache_snoop_ctrl_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic        datomic;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        cctrans;
    logic        ccwrite;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;

    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dmemload, dhit,
        output dREN, dWEN, daddr, dstore,
        input  dload, dwait,
        output cctrans, ccwrite,
        input  ccwait, ccinv, ccsnoopaddr
    );

    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dmemload, dhit,
        input  dREN, dWEN, daddr, dstore,
        output dload, dwait,
        input  cctrans, ccwrite,
        output ccwait, ccinv, ccsnoopaddr
    );
endinterface

// File: rtl/dcache_snoop_ctrl.sv
// Per-core MSI snooping data cache controller, direct-mapped, one-word lines.
// Serves loads/stores (hits combinationally), fills lines with coherence
// intent, writes back dirty victims, and answers snoops from the controller.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   cif  - dcache_snoop_ctrl_if.slave: processor request/response, bus
//          fill/writeback and snoop signals
// Optional feature: define DCACHE_LLSC_EN to enable LL/SC via cif.datomic.
module dcache_snoop_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic               CLK,
    input  logic               RST,
    dcache_snoop_ctrl_if.slave cif
);
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WB, FETCH, SNOOP} fsm_t;
    typedef enum logic [1:0] {LINE_I, LINE_S, LINE_M} line_t;

    fsm_t                state_reg, state_next, ret_reg, ret_next;
    line_t               line_reg [LINES];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx, snp_idx;
    logic [TAG_BITS-1:0]   req_tag, snp_tag;
    line_t                 req_line, snp_line;
    logic                  req_present, snp_match, snp_dirty;

    // Snoop result is latched while ccwait is high and only applied to the
    // line when ccwait falls, so the response stays stable for the whole snoop.
    logic [INDEX_BITS-1:0] snp_idx_reg, snp_idx_next;
    logic                  snp_dirty_reg, snp_dirty_next;
    logic                  snp_inv_reg, snp_inv_next;

    logic                  line_we;
    logic [INDEX_BITS-1:0] line_widx;
    line_t                 line_wval;
    logic                  fill_we, store_we;

    logic sc_op, sc_fail, ll_set, link_clr, snoop_inv_cyc;

    assign req_idx     = cif.dmemaddr[INDEX_BITS+1:2];
    assign req_tag     = cif.dmemaddr[31:INDEX_BITS+2];
    assign req_line    = line_reg[req_idx];
    assign req_present = (req_line != LINE_I) && (tag_mem[req_idx] == req_tag);

    assign snp_idx   = cif.ccsnoopaddr[INDEX_BITS+1:2];
    assign snp_tag   = cif.ccsnoopaddr[31:INDEX_BITS+2];
    assign snp_line  = line_reg[snp_idx];
    assign snp_match = (snp_line != LINE_I) && (tag_mem[snp_idx] == snp_tag);
    assign snp_dirty = snp_match && (snp_line == LINE_M);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cif.dmemaddr[1:0], cif.ccsnoopaddr[1:0]};

`ifdef DCACHE_LLSC_EN
    logic        link_valid_reg;
    logic [29:0] link_addr_reg;

    assign sc_op   = cif.datomic && cif.dmemWEN;
    assign sc_fail = sc_op && !(link_valid_reg && (link_addr_reg == cif.dmemaddr[31:2]));

    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid_reg <= 1'b0;
            link_addr_reg  <= '0;
        end else if (link_clr ||
                     (snoop_inv_cyc && link_valid_reg &&
                      (link_addr_reg == cif.ccsnoopaddr[31:2]))) begin
            link_valid_reg <= 1'b0;
        end else if (ll_set) begin
            link_valid_reg <= 1'b1;
            link_addr_reg  <= cif.dmemaddr[31:2];
        end
    end
`else
    assign sc_op   = 1'b0;
    assign sc_fail = 1'b0;

    logic unused_llsc;
    assign unused_llsc = ^{ll_set, link_clr, snoop_inv_cyc};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            ret_reg       <= IDLE;
            snp_idx_reg   <= '0;
            snp_dirty_reg <= 1'b0;
            snp_inv_reg   <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                line_reg[i] <= LINE_I;
            end
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            snp_idx_reg   <= snp_idx_next;
            snp_dirty_reg <= snp_dirty_next;
            snp_inv_reg   <= snp_inv_next;
            if (line_we) begin
                line_reg[line_widx] <= line_wval;
            end
        end
    end

    // Tag/data arrays carry no reset; validity lives in line_reg.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= cif.dload;
        end else if (store_we) begin
            data_mem[req_idx] <= cif.dmemstore;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ret_next       = ret_reg;
        snp_idx_next   = snp_idx_reg;
        snp_dirty_next = snp_dirty_reg;
        snp_inv_next   = snp_inv_reg;
        line_we        = 1'b0;
        line_widx      = req_idx;
        line_wval      = LINE_I;
        fill_we        = 1'b0;
        store_we       = 1'b0;
        ll_set         = 1'b0;
        link_clr       = 1'b0;
        snoop_inv_cyc  = 1'b0;
        cif.dhit       = 1'b0;
        cif.dmemload   = '0;
        cif.dREN       = 1'b0;
        cif.dWEN       = 1'b0;
        cif.daddr      = '0;
        cif.dstore     = '0;
        cif.cctrans    = 1'b0;
        cif.ccwrite    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // A pending snoop wins over any processor request this cycle.
                if (!cif.ccwait) begin
                    if (cif.dmemWEN) begin
                        if (sc_fail) begin
                            cif.dhit = 1'b1;
                        end else if (req_present && req_line == LINE_M) begin
                            cif.dhit     = 1'b1;
                            store_we     = 1'b1;
                            cif.dmemload = sc_op ? 32'd1 : data_mem[req_idx];
                            link_clr     = sc_op;
                        end else if (!req_present && req_line == LINE_M) begin
                            state_next = WB;
                        end else begin
                            // Miss on a clean victim, or upgrade of an S line.
                            state_next = FETCH;
                        end
                    end else if (cif.dmemREN) begin
                        if (req_present) begin
                            cif.dhit     = 1'b1;
                            cif.dmemload = data_mem[req_idx];
                            ll_set       = cif.datomic;
                        end else if (req_line == LINE_M) begin
                            state_next = WB;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
            end
            WB: begin
                cif.dWEN   = 1'b1;
                cif.daddr  = {tag_mem[req_idx], req_idx, 2'b00};
                cif.dstore = data_mem[req_idx];
                if (!cif.dwait) begin
                    line_we    = 1'b1;
                    line_wval  = LINE_I;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                cif.dREN    = 1'b1;
                cif.cctrans = 1'b1;
                cif.ccwrite = cif.dmemWEN;
                cif.daddr   = {cif.dmemaddr[31:2], 2'b00};
                if (!cif.dwait) begin
                    fill_we    = 1'b1;
                    line_we    = 1'b1;
                    line_wval  = cif.dmemWEN ? LINE_M : LINE_S;
                    state_next = IDLE;
                end
            end
            SNOOP: begin
                if (cif.ccwait) begin
                    cif.cctrans = snp_match;
                    cif.ccwrite = snp_dirty;
                    if (snp_dirty) begin
                        cif.daddr  = {cif.ccsnoopaddr[31:2], 2'b00};
                        cif.dstore = data_mem[snp_idx];
                    end
                    snp_idx_next   = snp_idx;
                    snp_dirty_next = snp_dirty;
                    snp_inv_next   = snp_inv_reg || (cif.ccinv && snp_match);
                    snoop_inv_cyc  = cif.ccinv;
                end else begin
                    state_next = ret_reg;
                    line_widx  = snp_idx_reg;
                    if (snp_inv_reg) begin
                        line_we   = 1'b1;
                        line_wval = LINE_I;
                    end else if (snp_dirty_reg) begin
                        line_we   = 1'b1;
                        line_wval = LINE_S;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Any in-flight transfer has already committed above; park its
        // advanced state and restart it from scratch after the snoop.
        if (cif.ccwait && state_reg != SNOOP) begin
            ret_next       = state_next;
            state_next     = SNOOP;
            snp_dirty_next = 1'b0;
            snp_inv_next   = 1'b0;
        end

        if (RST) begin
            line_we      = 1'b0;
            fill_we      = 1'b0;
            store_we     = 1'b0;
            ll_set       = 1'b0;
            link_clr     = 1'b0;
            cif.dhit     = 1'b0;
            cif.dmemload = '0;
            cif.dREN     = 1'b0;
            cif.dWEN     = 1'b0;
            cif.daddr    = '0;
            cif.dstore   = '0;
            cif.cctrans  = 1'b0;
            cif.ccwrite  = 1'b0;
        end
    end
endmodule

// File: tb/tb_dcache_snoop_ctrl.sv
// Self-checking bench for dcache_snoop_ctrl: directed scenarios followed by
// randomized loads/stores/snoops checked against a line-level MSI model.
module tb_dcache_snoop_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dcache_snoop_ctrl_if bus();

    dcache_snoop_ctrl #(.INDEX_BITS(3)) dut (
        .CLK (clk),
        .RST (rst),
        .cif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per index a coherence state (0=I,1=S,2=M), tag, word;
    // plus a word-addressed backing memory.
    int          m_st   [8];
    logic [26:0] m_tag  [8];
    logic [31:0] m_data [8];
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
        return mem[a[31:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_dhit"}, 32'(bus.dhit), 0);
        chk({tag, "_dREN"}, 32'(bus.dREN), 0);
        chk({tag, "_dWEN"}, 32'(bus.dWEN), 0);
        chk({tag, "_cctrans"}, 32'(bus.cctrans), 0);
        chk({tag, "_daddr"}, bus.daddr, 0);
    endtask

    // One processor access; the bus responder drops dwait on the wlat-th WB
    // cycle and the flat-th FETCH cycle.
    task automatic access(input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wlat, input int flat);
        int          idx, exp_lat, cyc, wcnt, fcnt;
        bit          present, hit, do_wb, done, saw_wb;
        logic [26:0] tag;
        logic [31:0] vaddr, exp_load, got_load;
        idx      = int'(addr[4:2]);
        tag      = addr[31:5];
        present  = (m_st[idx] != 0) && (m_tag[idx] == tag);
        hit      = st ? (present && m_st[idx] == 2) : present;
        do_wb    = !present && (m_st[idx] == 2);
        exp_lat  = hit ? 0 : ((do_wb ? wlat : 0) + flat + 1);
        vaddr    = {m_tag[idx], idx[2:0], 2'b00};
        exp_load = hit ? m_data[idx] : mem_rd(addr);
        cyc = 0; wcnt = 0; fcnt = 0; done = 0; saw_wb = 0; got_load = '0;
        @(negedge clk);
        bus.dmemREN   = !st;
        bus.dmemWEN   = st;
        bus.dmemaddr  = addr;
        bus.dmemstore = wdata;
        bus.dwait     = 1'b1;
        while (!done && cyc < 64) begin
            #1;
            if (bus.dhit) begin
                done     = 1;
                got_load = bus.dmemload;
                chk("latency", cyc, exp_lat);
                if (!st) chk("load_data", bus.dmemload, exp_load);
                if (st && bus.datomic) chk("sc_result", bus.dmemload, 1);
            end else if (bus.dWEN) begin
                if (wcnt == 0) begin
                    saw_wb = 1;
                    chk("wb_addr", bus.daddr, vaddr);
                    chk("wb_data", bus.dstore, m_data[idx]);
                    chk("wb_cctrans", 32'(bus.cctrans), 0);
                end
                wcnt++;
                bus.dwait = (wcnt < wlat);
            end else if (bus.dREN) begin
                if (fcnt == 0) begin
                    chk("fetch_addr", bus.daddr, {addr[31:2], 2'b00});
                    chk("fetch_cctrans", 32'(bus.cctrans), 1);
                    chk("fetch_ccwrite", 32'(bus.ccwrite), 32'(st));
                end
                fcnt++;
                bus.dload = mem_rd(addr);
                bus.dwait = (fcnt < flat);
            end
            @(negedge clk);
            bus.dwait = 1'b1;
            cyc++;
        end
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        chk("completed", 32'(done), 1);
        chk("wb_issued", 32'(saw_wb), 32'(do_wb));
        if (!hit) begin
            if (do_wb) mem[vaddr[31:2]] = m_data[idx];
            m_tag[idx]  = tag;
            m_data[idx] = mem_rd(addr);
            m_st[idx]   = st ? 2 : 1;
        end
        if (st) m_data[idx] = wdata;
        $display("txn %s addr=0x%08h data=0x%08h cycles=%0d", st ? "store" : "load ",
                 addr, st ? wdata : got_load, cyc);
    endtask

    // Snoop issued while the cache is idle; ccwait held for hold SNOOP cycles.
    task automatic snoop(input logic [31:0] a, input bit inv, input int hold);
        int idx;
        bit match, dirty;
        idx   = int'(a[4:2]);
        match = (m_st[idx] != 0) && (m_tag[idx] == a[31:5]);
        dirty = match && (m_st[idx] == 2);
        @(negedge clk);
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = a;
        bus.ccinv       = inv;
        #1;
        chk("snp_entry_cctrans", 32'(bus.cctrans), 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            chk("snp_cctrans", 32'(bus.cctrans), 32'(match));
            chk("snp_ccwrite", 32'(bus.ccwrite), 32'(dirty));
            chk("snp_dREN", 32'(bus.dREN), 0);
            if (dirty) begin
                chk("snp_dstore", bus.dstore, m_data[idx]);
                chk("snp_daddr", bus.daddr, {a[31:2], 2'b00});
            end
        end
        @(negedge clk);
        bus.ccwait = 1'b0;
        bus.ccinv  = 1'b0;
        if (dirty) mem[a[31:2]] = m_data[idx];
        if (match && inv) m_st[idx] = 0;
        else if (dirty) m_st[idx] = 1;
        $display("txn snoop addr=0x%08h inv=%0d match=%0d dirty=%0d", a, inv, match, dirty);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 8; i++) begin
            m_st[i] = 0; m_tag[i] = '0; m_data[i] = '0;
        end
        bus.dmemREN = 0; bus.dmemWEN = 0; bus.datomic = 0;
        bus.dmemaddr = '0; bus.dmemstore = '0; bus.dload = '0; bus.dwait = 1;
        bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = '0;

        // Power-on reset with a request pending: outputs must stay quiet.
        rst = 1'b1;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_quiet("reset_cycle");
        @(negedge clk);
        rst = 1'b0;
        bus.dmemREN = 1'b0;
        #1;
        chk_quiet("post_reset");

        // Cold load, upgrade store, hit, dirty eviction, refill.
        access(0, 32'h100, 0, 1, 3);
        access(1, 32'h100, 32'hDEAD, 1, 2);
        access(0, 32'h100, 0, 1, 1);
        access(0, 32'h120, 0, 2, 2);
        access(1, 32'h100, 32'hBEEF, 1, 1);
        snoop(32'h100, 1, 2);
        access(0, 32'h100, 0, 1, 2);

        // Snoop (no match) arriving mid-FETCH of 0x200.
        @(negedge clk);
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h200; bus.dwait = 1'b1;
        #1; chk("mf_idle_dREN", 32'(bus.dREN), 0);
        @(negedge clk); #1; chk("mf_fetch1_dREN", 32'(bus.dREN), 1);
        @(negedge clk);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h300; bus.ccinv = 1'b0;
        #1; chk("mf_fetch2_dREN", 32'(bus.dREN), 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("mf_snoop_dREN", 32'(bus.dREN), 0);
            chk("mf_snoop_cctrans", 32'(bus.cctrans), 0);
            chk("mf_snoop_dhit", 32'(bus.dhit), 0);
        end
        @(negedge clk); bus.ccwait = 1'b0; #1;
        @(negedge clk); #1;
        chk("mf_resume_dREN", 32'(bus.dREN), 1);
        chk("mf_resume_daddr", bus.daddr, 32'h200);
        bus.dload = mem_rd(32'h200); bus.dwait = 1'b0;
        @(negedge clk); bus.dwait = 1'b1; #1;
        chk("mf_hit", 32'(bus.dhit), 1);
        chk("mf_load", bus.dmemload, mem_rd(32'h200));
        @(negedge clk); bus.dmemREN = 1'b0;
        m_tag[0] = 27'h10; m_data[0] = mem_rd(32'h200); m_st[0] = 1;
        $display("txn load  addr=0x00000200 with mid-fetch snoop of 0x00000300");

        // Randomized mix against the model.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            a = 32'h1000 | (32'($urandom_range(0, 31)) << 2);
            if (r < 15) snoop(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            else access(r < 55, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
        end

        // Reset in the middle of a writeback drops it.
        access(1, 32'h200, $urandom, 2, 2);
        @(negedge clk);
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h120; bus.dwait = 1'b1;
        @(negedge clk); #1; chk("rw_wb_dWEN", 32'(bus.dWEN), 1);
        @(negedge clk); rst = 1'b1; #1;
        chk_quiet("rw_reset_cycle");
        @(negedge clk); rst = 1'b0; bus.dmemREN = 1'b0; #1;
        chk_quiet("rw_post_reset");
        for (int i = 0; i < 8; i++) m_st[i] = 0;
        access(0, 32'h200, 0, 1, 1);

`ifdef DCACHE_LLSC_EN
        // LL, invalidating snoop, then SC must fail without traffic.
        bus.datomic = 1'b1; access(0, 32'h40, 0, 1, 2);
        bus.datomic = 1'b0; snoop(32'h40, 1, 1);
        @(negedge clk);
        bus.datomic = 1'b1; bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h40; bus.dmemstore = 32'h1234;
        #1;
        chk("sc_fail_dhit", 32'(bus.dhit), 1);
        chk("sc_fail_load", bus.dmemload, 0);
        chk("sc_fail_dREN", 32'(bus.dREN), 0);
        @(negedge clk); #1;
        chk("sc_fail_no_fetch", 32'(bus.dREN), 0);
        bus.dmemWEN = 1'b0; bus.datomic = 1'b0;
        access(0, 32'h40, 0, 1, 1);
        // Same sequence without the snoop succeeds.
        bus.datomic = 1'b1; access(0, 32'h40, 0, 1, 1);
        access(1, 32'h40, 32'h1234, 1, 2);
        bus.datomic = 1'b0;
        access(0, 32'h40, 0, 1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_snoop_ctrl.md
# dcache_snoop_ctrl

Per-core coherent data cache controller: the cache-side end of the MSI snooping bus driven by the memory controller. Serves processor loads and stores from a small direct-mapped MSI cache and issues fill and writeback requests with coherence intent. Answers snoops from the controller, supplying dirty data, downgrading, or invalidating lines. One instance sits between each core's datapath and its `ccif` slice.

## Interface
- `INDEX_BITS`, 3: set index width; `2**INDEX_BITS` one-word lines, direct-mapped.
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `dmemREN`  in  1  processor load request.
- `dmemWEN`  in  1  processor store request; if `dmemREN` is also high, the store takes priority.
- `dmemaddr`  in  32  byte address; `[1:0]` ignored, index `[INDEX_BITS+1:2]`, tag above the index.
- `dmemstore`  in  32  store data.
- `datomic`  in  1  LL/SC qualifier; used only with `DCACHE_LLSC_EN`.
- `dmemload`  out  32  load data; SC result when atomic.
- `dhit`  out  1  request complete this cycle.
- `dREN`  out  1  bus read (fill).
- `dWEN`  out  1  bus write (eviction writeback).
- `daddr`  out  32  bus address.
- `dstore`  out  32  writeback or snoop-supplied data.
- `dload`  in  32  fill data.
- `dwait`  in  1  bus busy; the transfer completes in the cycle it is low while `dREN` or `dWEN` is high.
- `cctrans`  out  1  during a request: coherence transaction. During a snoop: line present.
- `ccwrite`  out  1  during a request: intent to modify. During a snoop: line Modified.
- `ccwait`  in  1  controller is snooping this cache.
- `ccinv`  in  1  invalidate the snooped line.
- `ccsnoopaddr`  in  32  snoop address.

## Operation
- Line state is I, S, or M, plus a tag and a 32-bit word. Reset sets every line to I, the state to IDLE, and the link to invalid. All outputs read 0 in the reset cycle and the cycle after.
- FSM states:
  - IDLE
    - A hit is a load to S or M, or a store to M. It is served combinationally: `dhit=1`. A store writes the word at the next edge.
    - A store to an S line goes to FETCH with `ccwrite=1`; this is the upgrade, and the line is refetched.
    - A miss on a victim in I or S goes to FETCH.
    - A miss on a victim in M goes to WB.
  - WB
    - Outputs: `dWEN=1`, `daddr={victim tag, index, 2'b00}`, `dstore`=victim word, `cctrans=0`.
    - When `dwait` is low: victim goes to I, then to FETCH.
  - FETCH
    - Outputs: `dREN=1`, `cctrans=1`, `ccwrite=dmemWEN`, `daddr={dmemaddr[31:2],2'b00}`.
    - When `dwait` is low: write `dload` and the tag, state ← S for a load or M for a store, then to IDLE. The hit happens in IDLE on the next cycle.
  - SNOOP
    - Entered from IDLE, WB or FETCH whenever `ccwait=1`. The return state is saved.
    - `ccwait` has priority over a new or in-flight own request. While in SNOOP, `dREN` and `dWEN` are 0 and `dhit=0`.
    - Match means the line at the `ccsnoopaddr` index is not I and its tag equals the snoop tag.
    - `cctrans`=match and `ccwrite`=match with line in M. On match with M, `daddr=ccsnoopaddr` and `dstore`=line word.
    - `ccinv=1` with match: line ← I at the edge.
    - On return, when `ccwait` falls: a matched M line that was not invalidated ← S. Return to the saved state, reissuing its request from the start.
- Processor inputs must stay stable until `dhit`.
- Arithmetic: `daddr` bits `[1:0]` are always 0. No other arithmetic.

## Timing
- Hit latency: 0 cycles, combinational `dhit`.
- Clean miss: FETCH for N cycles until `dwait` falls, then a hit on the following IDLE cycle, so N+1 cycles total.
- Dirty miss: WB (M cycles), then FETCH (N cycles), then hit: M+N+1 cycles.
- Snoop response (`cctrans`/`ccwrite`/`dstore`) is valid in the first SNOOP cycle and is held while `ccwait=1`.
- Simultaneous `ccwait` and a transfer completing (`dwait` low) in WB or FETCH: the transfer commits first, the state advances as normal, and SNOOP is entered with the advanced state saved as the return state.
- A snoop that invalidates the line being fetched has no effect on the later fill.
- Reset mid-transaction: all outputs return to 0 next cycle and every line goes to I; a pending writeback is dropped.

## Configuration
- `DCACHE_LLSC_EN` defined:
  - `datomic` with a load sets link ← address and completes as a normal load.
  - `datomic` with a store (SC) succeeds only if the link is valid and matches; it then proceeds as a store and returns `dmemload=1`.
  - A failed SC returns `dhit=1` with `dmemload=0`, writes nothing, and issues no bus traffic.
  - The link is cleared by a successful SC, by a snoop `ccinv` matching the link address, and by reset.
- Not defined: `datomic` is ignored; stores behave normally and `dmemload` is the cache word.

## Test plan
- Cold load 0x100 with `dwait` low after 3 cycles → FETCH with `dREN=1`, `cctrans=1`, `ccwrite=0`, `daddr=0x100`. `dhit` on cycle 4, `dmemload=dload`, line in S.
- Store to 0x100 while the line is S → FETCH with `ccwrite=1`. Line in M, `dhit`, and a following load returns the stored value.
- Load 0x120 (same index, 3 bits) while 0x100 holds M=0xDEAD → WB with `dWEN=1`, `daddr=0x100`, `dstore=0xDEAD`, then FETCH 0x120.
- `ccwait=1`, `ccsnoopaddr=0x100` with line M=0xBEEF, `ccinv=1` → `cctrans=1`, `ccwrite=1`, `dstore=0xBEEF`. Line in I afterwards, and a next load of 0x100 misses.
- `ccwait` raised mid-FETCH of 0x200, snooping 0x300 (no match) → `dREN` drops, `cctrans=0`, FETCH resumes when `ccwait` falls and completes.
- `DCACHE_LLSC_EN`: LL 0x40, then a snoop with `ccinv` on 0x40, then SC 0x40 → `dmemload=0` and memory unchanged. Repeating without the snoop → `dmemload=1`.
